adc_spi_rx: RTL

ADC_SPI_RX -- requirements
Module: adc_spi_rx

---
 rtl/adc_spi_rx.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/adc_spi_rx.sv
// Receives fixed-length frames from an ADC over SPI using oversampled, synchronized, glitch-filtered inputs.
// Define ADC_SPI_RX_TIMEOUT_EN to abort frames whose SPI clock stalls for TIMEOUT_CYCLES.
module adc_spi_rx #(
    parameter int WORD_BITS      = 16,
    parameter int NUM_WORDS      = 3,
    parameter int SPI_MODE       = 0,
    parameter int MSB_FIRST      = 1,
    parameter int FILTER_CYCLES  = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic                           i_spi_cs_n,
    input  logic                           i_spi_clock,
    input  logic                           i_spi_data,
    output logic [NUM_WORDS*WORD_BITS-1:0] o_data,
    output logic                           o_data_valid,
    output logic                           o_frame_error,
    output logic                           o_busy,
    output logic [1:0]                     o_fsm_state
);
    localparam int FW  = NUM_WORDS * WORD_BITS;
    localparam int BCW = $clog2(WORD_BITS);
    localparam int WCW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic CPOL        = (SPI_MODE >= 2);
    localparam logic SAMPLE_RISE = (SPI_MODE == 0) || (SPI_MODE == 3);
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(WORD_BITS - 1);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_WORDS - 1);
    localparam logic [3:0]     FILT_LAST = 4'(FILTER_CYCLES - 1);
    // Bit 0 = chip select, bit 1 = SPI clock, bit 2 = data.
    localparam logic [2:0]     IN_RST    = {1'b0, CPOL, 1'b1};

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RECV    = 2'd1;
    localparam logic [1:0] ST_WAIT_CS = 2'd2;

    logic [2:0] sync1_q, sync2_q, filt_q;
    logic [1:0] prev_q;
    logic [3:0] fcnt_q [3];
    logic [1:0] prime_q;
    logic       armed_q;

    // A frame may only start after CS has been seen high once the synchronizers hold real samples.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sync1_q <= IN_RST;
            sync2_q <= IN_RST;
            filt_q  <= IN_RST;
            prev_q  <= IN_RST[1:0];
            for (int i = 0; i < 3; i++) fcnt_q[i] <= 4'd0;
            prime_q <= 2'd0;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= {i_spi_data, i_spi_clock, i_spi_cs_n};
            sync2_q <= sync1_q;
            prev_q  <= filt_q[1:0];
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= 4'd0;
                end else if (fcnt_q[i] == FILT_LAST) begin
                    filt_q[i] <= sync2_q[i];
                    fcnt_q[i] <= 4'd0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 4'd1;
                end
            end
            if (prime_q != 2'd2) prime_q <= prime_q + 2'd1;
            else if (sync2_q[0] && filt_q[0]) armed_q <= 1'b1;
        end
    end

    logic cs_rise, cs_fall, sample_edge;
    assign cs_rise     = filt_q[0] & ~prev_q[0];
    assign cs_fall     = ~filt_q[0] & prev_q[0] & armed_q;
    assign sample_edge = SAMPLE_RISE ? (filt_q[1] & ~prev_q[1]) : (~filt_q[1] & prev_q[1]);

    logic [1:0]       state_q, state_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WCW-1:0]   word_cnt_q, word_cnt_d;
    logic [WORD_BITS-1:0] shift_q, shift_d, shifted;
    logic [FW-1:0]    stage_q, stage_d, data_q, data_d;
    logic             valid_q, valid_d, err_q, err_d, frame_done;
`ifdef ADC_SPI_RX_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT_CYCLES - 1);
    logic [TCW-1:0] to_cnt_q, to_cnt_d;
`endif

    assign shifted = (MSB_FIRST != 0) ? {shift_q[WORD_BITS-2:0], filt_q[2]}
                                      : {filt_q[2], shift_q[WORD_BITS-1:1]};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        shift_d    = shift_q;
        stage_d    = stage_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        frame_done = 1'b0;
`ifdef ADC_SPI_RX_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d    = ST_RECV;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    stage_d    = '0;
`ifdef ADC_SPI_RX_TIMEOUT_EN
                    to_cnt_d   = '0;
`endif
                end
            end
            ST_RECV: begin
                if (sample_edge) begin
                    shift_d = shifted;
`ifdef ADC_SPI_RX_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        stage_d[int'(word_cnt_q)*WORD_BITS +: WORD_BITS] = shifted;
                        word_cnt_d = word_cnt_q + WCW'(1);
                        frame_done = (word_cnt_q == LAST_WORD);
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
                // Completion wins over a simultaneous CS rise.
                if (frame_done) begin
                    data_d  = stage_d;
                    valid_d = 1'b1;
                    state_d = ST_WAIT_CS;
                end else if (cs_rise) begin
                    err_d   = 1'b1;
                    stage_d = '0;
                    state_d = ST_IDLE;
`ifdef ADC_SPI_RX_TIMEOUT_EN
                end else if (!sample_edge && to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    stage_d = '0;
                    state_d = ST_WAIT_CS;
                end else if (!sample_edge) begin
                    to_cnt_d = to_cnt_q + TCW'(1);
`endif
                end
            end
            ST_WAIT_CS: begin
                if (filt_q[0]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            shift_q    <= '0;
            stage_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
`ifdef ADC_SPI_RX_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            shift_q    <= shift_d;
            stage_q    <= stage_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
`ifdef ADC_SPI_RX_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
`endif
        end
    end

    assign o_data        = data_q;
    assign o_data_valid  = valid_q;
    assign o_frame_error = err_q;
    assign o_busy        = (state_q == ST_RECV);
    assign o_fsm_state   = state_q;
endmodule
